// File: rtl/key_event_queue.sv
// Key event queue: synchronises five virtual-key levels, turns rising edges
// into press events, adds typematic repeats for a lone held key, and buffers
// the events in a first-word-fall-through FIFO drained by a pop handshake.
module key_event_queue #(
  parameter int DEPTH         = 4,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int CW            = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     vk_left,
  input  logic                     vk_check,
  input  logic                     vk_right,
  input  logic                     vk_up,
  input  logic                     vk_down,
  input  logic                     pop,
  output logic                     ev_valid,
  output logic [2:0]               ev_key,
  output logic                     ev_repeat,
  output logic [$clog2(DEPTH):0]   count,
  output logic [4:0]               held,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} rpt_state_e;

  typedef struct packed {
    logic [2:0] key;
    logic       rpt;
  } entry_t;

  logic [4:0]    vk_in;
  logic [4:0]    s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
  logic [4:0]    pending_q, pending_d, pending_rpt_q, pending_rpt_d;
  rpt_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    rkey_q, rkey_d;
  logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic          overflow_q, overflow_d;
  entry_t        mem_q [DEPTH];

  logic [4:0]    rise, tick_mask;
  logic          one_hot, tick;
  logic          push_req, do_push, do_pop, drop, empty, full;
  logic [2:0]    push_idx;
  logic [AW:0]   count_w;
  entry_t        wdata, head;

  assign vk_in   = {vk_down, vk_up, vk_right, vk_check, vk_left};
  assign rise    = s2_q & ~prev_q;
  assign one_hot = (s2_q != 5'd0) && ((s2_q & (s2_q - 5'd1)) == 5'd0);

  // Synchroniser chain and edge-detect history.
  always_comb begin
    s1_d   = vk_in;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  // Repeat FSM: arm on a lone held key, tick after the delay, then periodically.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    rkey_d  = rkey_q;
    tick    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (one_hot) begin
          state_d = ST_DELAY;
          cnt_d   = '0;
          rkey_d  = s2_q;
        end
      end
      ST_DELAY: begin
        if (s2_q != rkey_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DLY_LAST) begin
          tick    = 1'b1;
          state_d = ST_REPEAT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_REPEAT: begin
        if (s2_q != rkey_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == PER_LAST) begin
          tick  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tick_mask = tick ? rkey_q : 5'd0;

  // Pending capture and fixed-priority arbiter (lowest index wins).
  always_comb begin
    pending_d     = pending_q;
    pending_rpt_d = pending_rpt_q;
    push_req      = |pending_q;
    push_idx      = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (pending_q[i]) push_idx = 3'(i);
    end
    if (push_req) pending_d[push_idx] = 1'b0;
    // A fresh press overrides a repeat flag for the same key.
    pending_d     = pending_d | tick_mask | rise;
    pending_rpt_d = (pending_rpt_d | tick_mask) & ~rise;
  end

  // FIFO pointer arithmetic; a push into a full FIFO survives only with a pop.
  always_comb begin
    count_w    = wptr_q - rptr_q;
    empty      = (count_w == '0);
    full       = (count_w == FULL_CNT);
    do_pop     = pop & ~empty;
    do_push    = push_req & (~full | do_pop);
    drop       = push_req & full & ~do_pop;
    wptr_d     = wptr_q + {{AW{1'b0}}, do_push};
    rptr_d     = rptr_q + {{AW{1'b0}}, do_pop};
    overflow_d = overflow_q | drop;
    wdata.key  = push_idx + 3'd1;
    wdata.rpt  = pending_rpt_q[push_idx];
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset_n) begin
      s1_q          <= '0;
      s2_q          <= '0;
      prev_q        <= '0;
      pending_q     <= '0;
      pending_rpt_q <= '0;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      rkey_q        <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      overflow_q    <= 1'b0;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      prev_q        <= prev_d;
      pending_q     <= pending_d;
      pending_rpt_q <= pending_rpt_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rkey_q        <= rkey_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      overflow_q    <= overflow_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; empty gates its outputs, so stale words never show.
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

  assign head      = mem_q[rptr_q[AW-1:0]];
  assign ev_valid  = ~empty;
  assign ev_key    = empty ? 3'd0 : head.key;
  assign ev_repeat = empty ? 1'b0 : head.rpt;
  assign count     = count_w;
  assign held      = s2_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed testbench for key_event_queue with shortened repeat timing.
module tb_key_event_queue;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       vk_left, vk_check, vk_right, vk_up, vk_down, pop;
  logic       ev_valid, ev_repeat, overflow;
  logic [2:0] ev_key;
  logic [2:0] count;
  logic [4:0] held;

  int n_tests = 0;
  int n_fail  = 0;

  key_event_queue #(
    .DEPTH(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5), .CW(32)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .vk_left(vk_left), .vk_check(vk_check), .vk_right(vk_right),
    .vk_up(vk_up), .vk_down(vk_down), .pop(pop),
    .ev_valid(ev_valid), .ev_key(ev_key), .ev_repeat(ev_repeat),
    .count(count), .held(held), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Watchdog: the directed sequence needs only a few hundred cycles.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    int ev_at  [8];
    int ev_k   [8];
    int ev_r   [8];
    int n_ev;
    int exp_at [5] = '{4, 24, 29, 34, 39};

    reset_n = 1'b0;
    {vk_left, vk_check, vk_right, vk_up, vk_down, pop} = '0;
    step(3);
    check("rst_valid", ev_valid, 0);
    check("rst_key", ev_key, 0);
    check("rst_repeat", ev_repeat, 0);
    check("rst_count", count, 0);
    check("rst_held", held, 0);
    check("rst_overflow", overflow, 0);
    reset_n = 1'b1;
    step(5);

    // Single press latency and pop.
    vk_left = 1'b1;
    step(3);
    check("lat_not_yet", ev_valid, 0);
    step(1);
    check("press_valid", ev_valid, 1);
    check("press_key", ev_key, 1);
    check("press_rpt", ev_repeat, 0);
    check("press_count", count, 1);
    check("press_held", held, 5'b00001);
    vk_left = 1'b0;
    pop = 1'b1;
    step(1);
    pop = 1'b0;
    check("pop_valid", ev_valid, 0);
    check("pop_count", count, 0);
    step(4);

    // Simultaneous presses drain in priority order.
    {vk_check, vk_up, vk_down} = 3'b111;
    step(4);
    check("multi_first_cnt", count, 1);
    check("multi_first_key", ev_key, 2);
    step(2);
    check("multi_count", count, 3);
    check("multi_head", ev_key, 2);
    pop = 1'b1;
    step(1);
    check("multi_pop1_key", ev_key, 4);
    check("multi_pop1_cnt", count, 2);
    step(1);
    check("multi_pop2_key", ev_key, 5);
    check("multi_pop2_rpt", ev_repeat, 0);
    step(1);
    check("multi_drained", count, 0);
    pop = 1'b0;
    {vk_check, vk_up, vk_down} = 3'b000;
    step(4);

    // Typematic repeat on vk_right: press at i=4, repeats at 24,29,34,39.
    n_ev = 0;
    for (int i = 1; i <= 60; i++) begin
      vk_right = (i <= 40);
      pop = ev_valid;
      step(1);
      if (ev_valid && n_ev < 8) begin
        ev_at[n_ev] = i;
        ev_k[n_ev]  = int'(ev_key);
        ev_r[n_ev]  = int'(ev_repeat);
        n_ev++;
      end
    end
    pop = 1'b0;
    check("rpt_num_events", n_ev, 5);
    for (int j = 0; j < 5; j++) begin
      check($sformatf("rpt_ev%0d_cycle", j), ev_at[j], exp_at[j]);
      check($sformatf("rpt_ev%0d_key", j), ev_k[j], 3);
      check($sformatf("rpt_ev%0d_flag", j), ev_r[j], (j == 0) ? 0 : 1);
    end
    check("rpt_no_overflow", overflow, 0);

    // Overflow: five presses into a 4-deep FIFO, down is lost.
    {vk_left, vk_check, vk_right, vk_up, vk_down} = 5'b11111;
    step(7);
    check("ovf_full_cnt", count, 4);
    check("ovf_not_yet", overflow, 0);
    step(1);
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 4);
    check("ovf_head", ev_key, 1);
    {vk_left, vk_check, vk_right, vk_up, vk_down} = 5'b00000;
    step(4);
    vk_left = 1'b1;
    step(3);
    pop = 1'b1;
    step(1);
    pop = 1'b0;
    vk_left = 1'b0;
    check("full_pushpop_cnt", count, 4);
    check("full_pushpop_head", ev_key, 2);
    check("ovf_sticky", overflow, 1);
    pop = 1'b1;
    step(1);
    check("drain_key3", ev_key, 3);
    step(1);
    check("drain_key4", ev_key, 4);
    step(1);
    check("drain_key1", ev_key, 1);
    check("drain_key1_rpt", ev_repeat, 0);
    step(1);
    check("drain_empty_cnt", count, 0);
    check("drain_empty_valid", ev_valid, 0);

    // Pop while empty is ignored.
    step(2);
    pop = 1'b0;
    check("empty_pop_cnt", count, 0);
    check("empty_pop_valid", ev_valid, 0);
    check("empty_pop_key", ev_key, 0);

    // Reset with a queued event and vk_up held through it.
    vk_up = 1'b1;
    step(4);
    check("pre_rst_count", count, 1);
    reset_n = 1'b0;
    step(3);
    check("mid_rst_count", count, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_held", held, 0);
    reset_n = 1'b1;
    step(3);
    check("post_rst_not_yet", ev_valid, 0);
    step(1);
    check("post_rst_valid", ev_valid, 1);
    check("post_rst_key", ev_key, 4);
    check("post_rst_count", count, 1);
    check("post_rst_held", held, 5'b01000);
    check("post_rst_ovf", overflow, 0);
    pop = 1'b1;
    step(1);
    pop = 1'b0;
    vk_up = 1'b0;
    step(5);
    check("post_rst_one_event", count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_event_queue.md
Name: key_event_queue

Overview:
- Sits directly downstream of the PS/2 keyboard decoder, which produces five level-type virtual-key lines (left, check, right, up, down).
- The block synchronises these lines into the system clock domain and turns rising edges into discrete press events.
- It generates typematic auto-repeat events for a single held key.
- Events are buffered in a small first-word-fall-through (FWFT) FIFO that the game control FSM drains with a pop handshake.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
REPEAT_DELAY, 50_000_000, cycles a lone key must be held before the first repeat event (0.5 s at 100 MHz)
REPEAT_PERIOD, 10_000_000, cycles between subsequent repeat events
CW, 32, width of the repeat counter; must hold REPEAT_DELAY

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk
vk_left  in  1  key level from PS/2 decoder; not synchronous to clk
vk_check  in  1  key level, as above
vk_right  in  1  key level, as above
vk_up  in  1  key level, as above
vk_down  in  1  key level, as above
pop  in  1  consumer takes the head entry this cycle
ev_valid  out  1  FIFO non-empty; head entry is valid
ev_key  out  3  head key code: 1=left, 2=check, 3=right, 4=up, 5=down
ev_repeat  out  1  head entry is an auto-repeat event (0 = genuine press)
count  out  clog2(DEPTH)+1  number of FIFO entries
held  out  5  synchronised key levels {down,up,right,check,left}
overflow  out  1  sticky: at least one event was dropped

Behaviour:
- Reset (reset_n=0 at a clk edge) clears all state:
  - synchroniser flops, prev, pending, pending_rpt, repeat counter, FIFO pointers, overflow.
  - Outputs after reset: ev_valid=0, ev_key=0, ev_repeat=0, count=0, held=0, overflow=0.
  - A key still held when reset deasserts yields one press event, because prev resets to 0.
  - Reset mid-operation discards queued events.
- Synchroniser: two-flop chain per line, s1 then s2. held = s2.
- Edge detect: prev <= s2 every cycle; rise = s2 & ~prev.
- Pending capture:
  - pending[i] is set on rise[i], and pending_rpt[i] is cleared at the same time, so a press overrides a repeat.
  - A repeat tick sets pending[i] and pending_rpt[i].
  - A release does not cancel a pending event.
- Push arbiter, each cycle:
  - Selects the lowest set index of pending (priority left > check > right > up > down).
  - Writes {code = index+1, pending_rpt[index]} into the FIFO and clears that pending bit.
  - At most one push per cycle; simultaneous presses drain in priority order on consecutive cycles.
- Full handling:
  - A push while count==DEPTH and pop==0 is dropped: the pending bit is cleared and overflow is set.
  - Push and pop together when full both succeed; count stays DEPTH.
- Pop rules:
  - pop with ev_valid=1 advances the read pointer.
  - pop with ev_valid=0 is ignored; count never underflows.
  - Push and pop together when not full leave count unchanged.
- FIFO outputs: FWFT. ev_key and ev_repeat show the head entry whenever ev_valid=1, and are 0 when empty.
- Press latency: a vk line rising before clk edge E gives ev_valid=1 after edge E+3, assuming an empty FIFO and no higher-priority pending bit:
  - E: s1
  - E+1: s2
  - E+2: pending
  - E+3: FIFO write
- Repeat FSM states: IDLE, DELAY, REPEAT.
  - IDLE → DELAY when exactly one held bit is set; the counter loads 0.
  - DELAY: the counter increments. At REPEAT_DELAY-1 it issues a tick for that key, goes to REPEAT and clears the counter.
  - REPEAT: the counter increments. At REPEAT_PERIOD-1 it issues a tick and clears the counter.
  - Any change in s2 (release, extra key, different key) returns to IDLE that cycle, with no tick.
  - The FSM re-enters DELAY the next cycle if exactly one key is still held.
- Counter arithmetic is unsigned, CW bits wide, compared for equality; no wrap occurs within legal parameters.

Test Plan:
- Press vk_left at edge 10, FIFO empty -> ev_valid=1 after edge 13 with ev_key=1, ev_repeat=0, count=1. Pulse pop -> ev_valid=0, count=0.
- Raise vk_check, vk_up and vk_down in the same cycle -> three entries pushed on consecutive cycles in order 2, 4, 5; count=3.
- With REPEAT_DELAY=20 and REPEAT_PERIOD=5, hold vk_right for 40 cycles -> one press (code 3, rpt 0), then repeats (code 3, rpt 1) 20 cycles after the FSM enters DELAY and every 5 cycles after that; no repeats after release.
- With DEPTH=4, produce 5 presses with no pop -> count=4, overflow=1, and the fifth event is lost. Then pop and push in the same cycle while full -> count stays 4.
- Pop while empty -> count stays 0 and ev_valid=0. Hold vk_up through reset_n=0 for 3 cycles, then release reset -> queue cleared, overflow=0, and exactly one press event with code 4 appears.
